regfile_mp: RTL
===============

Name: regfile_mp

Overview:
- Parametrised multi-port general-purpose register file; successor to the fixed 2-read/1-write file in the decode stage.
- Configurable width, depth, read-port count and write-port count.
- Adds hardwired zero register, deterministic write-port priority, write-to-read bypass and a hardware clear sequencer that zeroes the array after reset or on request.
- Sits between decode (reads) and writeback (writes); `ready` gates pipeline issue.

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, register address width; DEPTH = 2**ADDR_W
NUM_RD, 2, number of read ports (1..4)
NUM_WR, 2, number of write ports (1..2)
ZERO_REG, 1, 1 = register 0 reads as zero and ignores writes

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
clr  in  1  synchronous soft clear request, single-cycle pulse
ready  out  1  high when clear sweep is done and the file accepts writes
re  in  NUM_RD  per-port read enable
raddr  in  NUM_RD*ADDR_W  packed read addresses, port i at [i*ADDR_W +: ADDR_W]
rdata  out  NUM_RD*DATA_W  packed read data, combinational
we  in  NUM_WR  per-port write enable
waddr  in  NUM_WR*ADDR_W  packed write addresses
wdata  in  NUM_WR*DATA_W  packed write data

Behaviour:
- FSM states: INIT, RUN.
- rst asserted: state <= INIT, sweep counter <= 0, ready <= 0. Array contents are not reset directly.
- INIT: each cycle writes 0 to entry[cnt] and increments cnt. When cnt == DEPTH-1, that entry is written and the next state is RUN, with ready=1 from the following cycle.
- Sweep latency is exactly DEPTH cycles after rst deasserts.
- RUN: clr=1 → next cycle INIT, cnt=0, ready=0.
- clr in INIT restarts the sweep at cnt=0.
- clr has priority over any same-cycle write: writes that cycle are dropped.
- Writes in INIT are ignored.
- Write: in RUN, for each port j with we[j]=1, entry[waddr_j] <= wdata_j on the clock edge.
- Two ports writing the same address in the same cycle: the higher port index wins.
- ZERO_REG=1: writes to address 0 are dropped.
- Read port i, evaluated combinationally in this order:
  1. re[i]=0 → rdata_i = 0.
  2. ready=0 → 0.
  3. ZERO_REG=1 and raddr_i=0 → 0.
  4. Bypass: any we[j]=1 with waddr_j == raddr_i → wdata of the highest such j (write-first).
  5. Otherwise entry[raddr_i].
- Bypass never applies to address 0 when ZERO_REG=1, and never applies while ready=0.
- rdata is a pure function of inputs and state; no latches. Every output path is fully assigned.
- Reset mid-sweep or mid-operation: immediate ready=0, sweep restarts after release.
- Widths: all address compares are ADDR_W bits. No wrap concerns beyond the counter terminating at DEPTH-1.

Decomposition:
- Shared defines file additions: RstEnable, WriteEnable, ReadEnable, ZeroWord, default DataBus/RegAddrBus widths, FSM state encodings REGF_INIT/REGF_RUN.
- Sub-module regfile_clr_seq: owns the FSM, sweep counter and ready. Outputs clear-write enable and clear address.
- Top level: owns the array, write-priority merge and per-port read/bypass muxes, built with a generate loop over NUM_RD.

Test Plan:
1. Reset release, default params → ready=0 for 32 cycles, then 1. Read every address → 0x00000000.
2. RUN: write port0 addr 5 = 0xDEADBEEF. Same cycle, read port1 addr 5 → 0xDEADBEEF (bypass). Next cycle, no write → still 0xDEADBEEF.
3. Same cycle: port0 writes addr 7 = 0x11111111, port1 writes addr 7 = 0x22222222 → bypass and stored value both 0x22222222.
4. Write addr 0 = 0xFFFFFFFF with ZERO_REG=1 → read addr 0 is 0 in the same and all later cycles. Rerun with ZERO_REG=0 → 0xFFFFFFFF.
5. Fill addr 3 = 0xA5A5A5A5, then pulse clr together with a write to addr 4 → ready low for 32 cycles; afterwards addr 3 and addr 4 both read 0.
6. Assert rst at sweep cnt=10 → ready stays 0; full 32-cycle sweep after release. re[i]=0 on any port → that port's rdata=0.

Source files
------------

// File: rtl/regfile_mp_pkg.sv
// Shared constants and types for the multi-port register file.
package regfile_mp_pkg;

  localparam logic RstEnable   = 1'b1;
  localparam logic WriteEnable = 1'b1;
  localparam logic ReadEnable  = 1'b1;

  localparam int unsigned DataBusW    = 32;
  localparam int unsigned RegAddrBusW = 5;

  localparam logic [DataBusW-1:0] ZeroWord = '0;

  // Clear-sequencer states: sweeping the array, or normal operation.
  typedef enum logic [0:0] {
    RegfInit = 1'b0,
    RegfRun  = 1'b1
  } regf_state_e;

endpackage

// File: rtl/regfile_clr_seq.sv
// Clear sequencer: sweeps every entry to zero after reset or on a clr request,
// then raises ready. Owns the FSM and the sweep counter.
module regfile_clr_seq
  import regfile_mp_pkg::*;
#(
  parameter int unsigned ADDR_W = RegAddrBusW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  output logic              ready,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);

  localparam logic [ADDR_W-1:0] LastAddr = '1;

  regf_state_e       state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              ready_q;

  // State, counter and ready registers; ready tracks the RUN state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable) begin
      state_q <= RegfInit;
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= (state_d == RegfRun);
    end
  end

  // Next-state: sweep until the last entry, clr restarts from entry 0.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      RegfInit: begin
        if (clr) begin
          cnt_d = '0;
        end else if (cnt_q == LastAddr) begin
          state_d = RegfRun;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ADDR_W'(1);
        end
      end
      RegfRun: begin
        if (clr) begin
          state_d = RegfInit;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = RegfInit;
        cnt_d   = '0;
      end
    endcase
  end

  assign ready    = ready_q;
  assign clr_we   = (state_q == RegfInit);
  assign clr_addr = cnt_q;

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with zero register, write priority,
// write-to-read bypass and a hardware clear sweep gating ready.
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int unsigned DATA_W   = DataBusW,
  parameter int unsigned ADDR_W   = RegAddrBusW,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned NUM_WR   = 2,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  output logic                     ready,
  input  logic [NUM_RD-1:0]        re,
  input  logic [NUM_RD*ADDR_W-1:0] raddr,
  output logic [NUM_RD*DATA_W-1:0] rdata,
  input  logic [NUM_WR-1:0]        we,
  input  logic [NUM_WR*ADDR_W-1:0] waddr,
  input  logic [NUM_WR*DATA_W-1:0] wdata
);

  localparam int unsigned Depth  = 1 << ADDR_W;
  localparam logic        ZeroEn = (ZERO_REG != 0);

  logic [DATA_W-1:0] mem_q [Depth];
  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;

  regfile_clr_seq #(
    .ADDR_W (ADDR_W)
  ) u_clr_seq (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .ready    (ready),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  // Array update: sweep zeroing in INIT; in RUN, ascending port order so the
  // highest-indexed writer to a shared address lands last. clr drops writes.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem_q[clr_addr] <= DATA_W'(ZeroWord);
    end else if (ready && !clr) begin
      for (int j = 0; j < int'(NUM_WR); j++) begin
        if (we[j] == WriteEnable &&
            !(ZeroEn && waddr[j*ADDR_W +: ADDR_W] == '0)) begin
          mem_q[waddr[j*ADDR_W +: ADDR_W]] <= wdata[j*DATA_W +: DATA_W];
        end
      end
    end
  end

  for (genvar i = 0; i < int'(NUM_RD); i++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rd;

    assign ra = raddr[i*ADDR_W +: ADDR_W];

    // Read mux: gated by re and ready, zero register, then write-first bypass.
    always_comb begin
      rd = '0;
      if (re[i] == ReadEnable && ready && !(ZeroEn && ra == '0)) begin
        rd = mem_q[ra];
        for (int j = 0; j < int'(NUM_WR); j++) begin
          if (we[j] == WriteEnable && waddr[j*ADDR_W +: ADDR_W] == ra) begin
            rd = wdata[j*DATA_W +: DATA_W];
          end
        end
      end
    end

    assign rdata[i*DATA_W +: DATA_W] = rd;
  end

endmodule
